// File: rtl/load_writeback_unit.sv
// load_writeback_unit: multi-cycle load unit between execute and the register-file
// write port. Issues a single req/ack bus read per legal load, aligns and extends the
// selected byte/half/word and writes it back for exactly one cycle.
// Optional feature macro: LOAD_TIMEOUT_EN (WAIT-state bus timeout -> fault).
module load_writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        loadValid,
    input  logic [2:0]  loadFunct3,
    input  logic [31:0] loadAddress,
    input  logic [4:0]  loadRd,
    output logic        busy,
    output logic        loadFault,
    output logic        memRequest,
    output logic [31:0] memAddress,
    input  logic        memAck,
    input  logic [31:0] memReadData,
    output logic [4:0]  addressForWriting,
    output logic [31:0] valueForWriting,
    output logic        writeEnable
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT      = 2'd1,
        S_WRITEBACK = 2'd2,
        S_FAULT     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic [29:0] word_addr_q;
    logic [31:0] data_q;
    logic        tmo_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    // Legal funct3 with natural alignment for its access size.
    function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = (lo[0] == 1'b0);
            3'b010:         ok = (lo == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Select the addressed byte/half from the bus word and sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LOAD_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Count WAIT cycles without an ack; cleared whenever the unit is not waiting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            tmo_cnt_q <= '0;
        end else if (!memAck) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Fires in the WAIT cycle that brings the count up to the limit.
    assign tmo_hit = (state_q == S_WAIT) && !memAck &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register and load context capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_addr_q <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && loadValid) begin
                funct3_q    <= loadFunct3;
                lane_q      <= loadAddress[1:0];
                rd_q        <= loadRd;
                word_addr_q <= loadAddress[31:2];
            end
        end
    end

    // Read data register, loaded only by an ack seen while waiting.
    always_ff @(posedge clock) begin
        if (state_q == S_WAIT && memAck) begin
            data_q <= memReadData;
        end
    end

    assign memAddress = {word_addr_q, 2'b00};

    // Next-state and output decode; ack takes priority over timeout.
    always_comb begin
        state_d           = state_q;
        busy              = 1'b0;
        memRequest        = 1'b0;
        loadFault         = 1'b0;
        writeEnable       = 1'b0;
        addressForWriting = '0;
        valueForWriting   = '0;
        case (state_q)
            S_IDLE: begin
                busy = loadValid;
                if (loadValid) begin
                    state_d = load_ok(loadFunct3, loadAddress[1:0]) ? S_WAIT : S_FAULT;
                end
            end
            S_WAIT: begin
                busy       = 1'b1;
                memRequest = 1'b1;
                if (memAck) begin
                    state_d = S_WRITEBACK;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                writeEnable       = (rd_q != 5'd0);
                addressForWriting = rd_q;
                valueForWriting   = extend_load(funct3_q, lane_q, data_q);
                state_d           = S_IDLE;
            end
            S_FAULT: begin
                loadFault = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Bench for load_writeback_unit: directed and random loads checked against a
// behavioural model of the load rules and cycle counts.
module tb_load_writeback_unit;

    localparam int TMO = 8;
`ifdef LOAD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        loadValid = 1'b0;
    logic [2:0]  loadFunct3 = '0;
    logic [31:0] loadAddress = '0;
    logic [4:0]  loadRd = '0;
    logic        busy, loadFault, memRequest, writeEnable;
    logic [31:0] memAddress, valueForWriting;
    logic        memAck = 1'b0;
    logic [31:0] memReadData = '0;
    logic [4:0]  addressForWriting;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    load_writeback_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .loadValid(loadValid), .loadFunct3(loadFunct3),
        .loadAddress(loadAddress), .loadRd(loadRd), .busy(busy), .loadFault(loadFault),
        .memRequest(memRequest), .memAddress(memAddress), .memAck(memAck),
        .memReadData(memReadData), .addressForWriting(addressForWriting),
        .valueForWriting(valueForWriting), .writeEnable(writeEnable)
    );

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_value(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> ((a % 4) * 8)) & 32'hFF;
        h = (d >> (((a / 2) % 2) * 16)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    // Present one load at the current IDLE cycle, ack after `waits` extra WAIT cycles,
    // and end in the following IDLE cycle with loadValid low.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                            input logic [31:0] d, input int waits, input string tag);
        int nbusy = 0, nreq = 0, nwr = 0, nflt = 0, wcyc = 0, cyc = 1;
        bit addr_bad = 1'b0, done = 1'b0;
        logic [4:0]  waddr = '0;
        logic [31:0] wval = '0;
        bit legal, tmo, exp_wr;
        int exp_req;
        legal   = ref_legal(f3, a);
        tmo     = legal && TMO_EN && (waits >= TMO);
        exp_req = !legal ? 0 : (tmo ? TMO : waits + 1);
        exp_wr  = legal && !tmo && (rd != 5'd0);

        loadValid = 1'b1; loadFunct3 = f3; loadAddress = a; loadRd = rd;
        memReadData = d; memAck = 1'b0;
        #1;
        while (!done && cyc <= 400) begin
            if (busy) nbusy++;
            if (loadFault) nflt++;
            if (writeEnable) begin nwr++; wcyc = cyc; waddr = addressForWriting; wval = valueForWriting; end
            if (memRequest) begin
                nreq++;
                if (memAddress !== (a & 32'hFFFF_FFFC)) addr_bad = 1'b1;
            end
            memAck = memRequest && (nreq == waits + 1);
            if (!busy) done = 1'b1;
            else begin @(posedge clock); #1; cyc++; end
        end
        vectors++;
        if (!done) begin miscompares++; $display("FAIL %s completion: no release after %0d cycles", tag, cyc); end
        vectors++;
        if (nbusy !== exp_req + 1) begin miscompares++; $display("FAIL %s busy_cycles: got %0d exp %0d", tag, nbusy, exp_req + 1); end
        vectors++;
        if (nreq !== exp_req) begin miscompares++; $display("FAIL %s req_cycles: got %0d exp %0d", tag, nreq, exp_req); end
        vectors++;
        if (addr_bad !== 1'b0) begin miscompares++; $display("FAIL %s memAddress: got %h exp %h", tag, memAddress, a & 32'hFFFF_FFFC); end
        vectors++;
        if (nflt !== int'(!legal || tmo)) begin miscompares++; $display("FAIL %s fault_pulses: got %0d exp %0d", tag, nflt, int'(!legal || tmo)); end
        vectors++;
        if (nwr !== int'(exp_wr)) begin miscompares++; $display("FAIL %s writes: got %0d exp %0d", tag, nwr, int'(exp_wr)); end
        if (exp_wr && nwr == 1) begin
            vectors++;
            if (waddr !== rd) begin miscompares++; $display("FAIL %s write_rd: got %0d exp %0d", tag, waddr, rd); end
            vectors++;
            if (wval !== ref_value(f3, a, d)) begin miscompares++; $display("FAIL %s write_value: got %h exp %h", tag, wval, ref_value(f3, a, d)); end
            vectors++;
            if (wcyc !== waits + 3) begin miscompares++; $display("FAIL %s write_cycle: got %0d exp %0d", tag, wcyc, waits + 3); end
        end
        @(posedge clock); #1;
        loadValid = 1'b0; memAck = 1'b0;
        #1;
        vectors++;
        if ({busy, memRequest, writeEnable, loadFault} !== 4'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: got %b exp 0000", tag, {busy, memRequest, writeEnable, loadFault});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; loadValid = 1'b0; memAck = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({busy, loadFault, memRequest, writeEnable, addressForWriting, valueForWriting, memAddress} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b flt=%b req=%b we=%b wa=%0d wv=%h ma=%h exp all 0",
                     busy, loadFault, memRequest, writeEnable, addressForWriting, valueForWriting, memAddress);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        run_load(3'b000, 32'h0000_1003, 5'd5, 32'h80FF_FF12, 0, "lb_sign");
        run_load(3'b101, 32'h0000_2002, 5'd6, 32'hBEEF_1234, 4, "lhu_wait4");
        run_load(3'b010, 32'h0000_3001, 5'd7, 32'h1111_2222, 0, "lw_misaligned");
        run_load(3'b011, 32'h0000_3000, 5'd8, 32'h3333_4444, 0, "illegal_f3");
        run_load(3'b010, 32'h0000_3000, 5'd0, 32'hDEAD_BEEF, 1, "lw_rd0");
        run_load(3'b001, 32'h0000_4001, 5'd9, 32'h5555_6666, 0, "lh_misaligned");
        run_load(3'b001, 32'h0000_4002, 5'd10, 32'h8001_7FFF, 2, "lh_upper_neg");
        run_load(3'b100, 32'h0000_4001, 5'd31, 32'h0000_F000, 0, "lbu_lane1");
    endtask

    task automatic test_reset_in_wait();
        loadValid = 1'b1; loadFunct3 = 3'b010; loadAddress = 32'h0000_4000; loadRd = 5'd7;
        memReadData = 32'hCAFE_F00D; memAck = 1'b0;
        @(posedge clock); #1;
        vectors++;
        if (memRequest !== 1'b1) begin miscompares++; $display("FAIL rst_wait_req: got %b exp 1", memRequest); end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1; loadValid = 1'b0; memAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({busy, loadFault, memRequest, writeEnable, addressForWriting, valueForWriting, memAddress} !== '0) begin
                miscompares++;
                $display("FAIL rst_wait_idle[%0d]: got busy=%b flt=%b req=%b we=%b ma=%h exp all 0",
                         i, busy, loadFault, memRequest, writeEnable, memAddress);
            end
            @(posedge clock); #1;
            memAck = 1'b0;
        end
    endtask

    task automatic test_timeout();
        run_load(3'b010, 32'h0000_5000, 5'd11, 32'h0BAD_F00D, 20, "no_ack_long");
        run_load(3'b010, 32'h0000_5004, 5'd12, 32'h600D_F00D, TMO - 1, "ack_at_limit");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_load(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                     int'($urandom_range(0, 5)), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_wait();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
